// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer
//
// Timing front-end for the Morse letter decoder. A raw telegraph key is
// synchronized and debounced. Key-down time is then measured against a
// programmable time unit to classify each symbol as a dot or a dash. Key-up
// time decides when a letter is closed (send) and when a word space is
// emitted (a second, empty send).
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active low
//   key_in     raw key, asynchronous, high = pressed
//   clear      user clear, level
//   dot        one-cycle dot strobe
//   dash       one-cycle dash strobe
//   send       one-cycle letter/space commit strobe
//   dec_reset  one-cycle decoder reset strobe (rising edge of clear)
//   sym_count  symbols accepted in the current letter
//   overflow   more than MAX_SYMBOLS presses seen in the current letter
//   key_active debounced key level
module morse_key_sequencer #(
  parameter int TICK_DIV         = 50_000_000,
  parameter int DEBOUNCE         = 500_000,
  parameter int DASH_UNITS       = 2,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7,
  parameter int MAX_SYMBOLS      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  input  logic       clear,
  output logic       dot,
  output logic       dash,
  output logic       send,
  output logic       dec_reset,
  output logic [2:0] sym_count,
  output logic       overflow,
  output logic       key_active
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int UNIT_W = $clog2(WORD_GAP_UNITS + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [UNIT_W-1:0] DASH_U   = UNIT_W'(DASH_UNITS);
  localparam logic [UNIT_W-1:0] LETTER_U = UNIT_W'(LETTER_GAP_UNITS);
  localparam logic [UNIT_W-1:0] WORD_U   = UNIT_W'(WORD_GAP_UNITS);
  localparam logic [2:0]        MAX_SYM  = 3'(MAX_SYMBOLS);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    WORD,
    LOCKOUT
  } state_t;

  state_t            state;
  logic              sync_1;
  logic              sync_2;
  logic              key_db;
  logic [DB_W-1:0]   db_cnt;
  logic [PRE_W-1:0]  prescale;
  logic [UNIT_W-1:0] unit_cnt;
  logic              clear_q;

  logic              tick_wrap;
  logic [UNIT_W-1:0] unit_next;
  logic              letter_hit;
  logic              word_hit;

  // Two-flop synchronizer followed by the debouncer. The debounced level only
  // follows the synchronized key once the two have disagreed for DEBOUNCE
  // consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      key_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_1 <= key_in;
      sync_2 <= sync_1;
      if (sync_2 != key_db) begin
        if (db_cnt == DB_LAST) begin
          key_db <= sync_2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign key_active = key_db;

  // The unit count as it will be after this cycle's prescaler step. Decisions
  // use this look-ahead value so that a press of N cycles measures
  // floor(N/TICK_DIV) units and the gap strobes land exactly on the unit
  // boundary rather than one cycle late.
  assign tick_wrap  = (prescale == PRE_LAST);
  assign unit_next  = (tick_wrap && unit_cnt != WORD_U) ? unit_cnt + UNIT_W'(1) : unit_cnt;
  assign letter_hit = tick_wrap && (unit_next == LETTER_U);
  assign word_hit   = tick_wrap && (unit_next == WORD_U);

  // Main sequencer. Every key_db edge while measuring coincides with a state
  // change, so restarting the timebase on state entry also restarts it on
  // every debounced edge. Clear overrides everything and is handled as a
  // level: while held, counts stay zero and the FSM parks in IDLE/LOCKOUT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      prescale  <= '0;
      unit_cnt  <= '0;
      sym_count <= '0;
      overflow  <= 1'b0;
      dot       <= 1'b0;
      dash      <= 1'b0;
      send      <= 1'b0;
      dec_reset <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      dot       <= 1'b0;
      dash      <= 1'b0;
      send      <= 1'b0;
      dec_reset <= 1'b0;
      clear_q   <= clear;

      if (clear) begin
        dec_reset <= !clear_q;
        sym_count <= '0;
        overflow  <= 1'b0;
        prescale  <= '0;
        unit_cnt  <= '0;
        state     <= key_db ? LOCKOUT : IDLE;
      end else begin
        case (state)
          IDLE: begin
            prescale <= '0;
            unit_cnt <= '0;
            if (key_db) state <= PRESS;
          end

          PRESS: begin
            if (!key_db) begin
              // Extra presses beyond MAX_SYMBOLS are dropped but flagged;
              // the letter is still closed by the normal gap send.
              if (sym_count < MAX_SYM) begin
                if (unit_next < DASH_U) dot <= 1'b1;
                else                    dash <= 1'b1;
                sym_count <= sym_count + 3'd1;
              end else begin
                overflow <= 1'b1;
              end
              prescale <= '0;
              unit_cnt <= '0;
              state    <= GAP;
            end else begin
              prescale <= tick_wrap ? '0 : prescale + PRE_W'(1);
              unit_cnt <= unit_next;
            end
          end

          GAP: begin
            // A press that starts on the threshold cycle still lets the
            // letter send fire; the new press is timed from this cycle.
            if (letter_hit) begin
              send      <= 1'b1;
              sym_count <= '0;
              overflow  <= 1'b0;
            end
            if (key_db) begin
              prescale <= '0;
              unit_cnt <= '0;
              state    <= PRESS;
            end else if (letter_hit) begin
              prescale <= '0;
              unit_cnt <= unit_next;
              state    <= WORD;
            end else begin
              prescale <= tick_wrap ? '0 : prescale + PRE_W'(1);
              unit_cnt <= unit_next;
            end
          end

          WORD: begin
            // unit_cnt carries over from GAP so the space is timed from the
            // last release, not from the letter send.
            if (word_hit) send <= 1'b1;
            if (key_db) begin
              prescale <= '0;
              unit_cnt <= '0;
              state    <= PRESS;
            end else if (word_hit) begin
              prescale <= '0;
              unit_cnt <= '0;
              state    <= IDLE;
            end else begin
              prescale <= tick_wrap ? '0 : prescale + PRE_W'(1);
              unit_cnt <= unit_next;
            end
          end

          LOCKOUT: begin
            prescale <= '0;
            unit_cnt <= '0;
            if (!key_db) state <= IDLE;
          end

          default: begin
            prescale <= '0;
            unit_cnt <= '0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

Timing front-end that turns a single raw telegraph-key input into the one-cycle `dot`, `dash`, `send` and decoder-reset strobes that drive the Morse letter decoder. It measures key-down and key-up durations against a programmable time unit. Press length classifies each symbol as dot or dash. A letter gap closes the letter with `send`. A word gap issues a second, empty `send`, which the decoder reports as the space code 6'b111111. The block sits between the board key/button inputs and the decoder.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clk cycles per Morse time unit; ≥ 2.
- `DEBOUNCE`, 500_000: cycles the synchronized key must be stable before the debounced key changes; ≥ 1.
- `DASH_UNITS`, 2: press of ≥ this many units is a dash, shorter is a dot.
- `LETTER_GAP_UNITS`, 3: key-up units that close a letter.
- `WORD_GAP_UNITS`, 7: key-up units, counted from the last release, that emit a space; must be > `LETTER_GAP_UNITS`.
- `MAX_SYMBOLS`, 6: symbols accepted per letter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `key_in`  in  1  raw key, asynchronous, high = pressed.
- `clear`  in  1  user clear, level, synchronous.
- `dot`  out  1  one-cycle dot strobe to decoder.
- `dash`  out  1  one-cycle dash strobe to decoder.
- `send`  out  1  one-cycle letter/space commit strobe to decoder.
- `dec_reset`  out  1  one-cycle decoder reset strobe.
- `sym_count`  out  3  symbols accepted in the current letter, 0..`MAX_SYMBOLS`.
- `overflow`  out  1  more than `MAX_SYMBOLS` presses seen in the current letter.
- `key_active`  out  1  debounced key level.

## Operation
- Input path: 2-FF synchronizer on `key_in`, then debounce counter. `key_db` takes the synchronized value only after it has differed from `key_db` for `DEBOUNCE` consecutive cycles. Any bounce restarts the count.
- Timebase: prescaler counts 0..`TICK_DIV`-1. It restarts at 0 on every `key_db` edge and every state entry. Each wrap increments `unit_cnt`, which saturates at `WORD_GAP_UNITS`.
- States:
  - IDLE: `key_db` rise goes to PRESS.
  - PRESS: on `key_db` fall, classify the symbol (below) and go to GAP with `unit_cnt` = 0.
  - GAP: `key_db` rise goes to PRESS. When `unit_cnt` reaches `LETTER_GAP_UNITS`, pulse `send`, clear `sym_count` and `overflow`, and go to WORD. `unit_cnt` keeps counting in WORD.
  - WORD: `key_db` rise goes to PRESS. When `unit_cnt` reaches `WORD_GAP_UNITS`, pulse `send` (space) and go to IDLE.
  - LOCKOUT: waits for `key_db` low, then goes to IDLE. Nothing is measured or emitted.
- Classification on release:
  - If `unit_cnt` < `DASH_UNITS`, pulse `dot`; otherwise pulse `dash`.
  - Pulse only if `sym_count` < `MAX_SYMBOLS`, then increment `sym_count`.
  - Otherwise emit nothing and set `overflow`. The letter is still closed normally by the gap `send`.
- Clear:
  - `clear` high in any state pulses `dec_reset` once, on its rising edge.
  - It zeroes `sym_count`, `overflow` and the counters, and suppresses `dot`/`dash`/`send` that cycle.
  - It goes to LOCKOUT if `key_db` = 1, else to IDLE.
- `dot`, `dash`, `send` and `dec_reset` are mutually exclusive and never high two consecutive cycles.
- Reset (`reset` = 0 at a clk edge):
  - State IDLE; all counters 0.
  - `key_db` = 0, synchronizer flops 0.
  - All outputs 0.
  - Reset mid-press discards the symbol.

## Timing
- `key_in` to `key_db`: 2 + `DEBOUNCE` cycles.
- All outputs are registered.
- Press of N cycles of `key_db` high gives `unit_cnt` = floor(N/`TICK_DIV`). It is a dash iff N ≥ `DASH_UNITS`·`TICK_DIV`.
- `dot`/`dash` is high on the cycle after the first `key_db` = 0 sample.
- Letter `send` is high exactly `LETTER_GAP_UNITS`·`TICK_DIV` + 1 cycles after the `key_db` fall.
- Space `send` is high exactly `WORD_GAP_UNITS`·`TICK_DIV` + 1 cycles after the `key_db` fall.
- A press beginning on the same cycle the gap threshold is hit:
  - The `send` still fires.
  - The new press is measured from that cycle.
- `dec_reset`: high on the cycle after `clear` is first sampled high.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEBOUNCE`=2, `DASH_UNITS`=2, `LETTER_GAP_UNITS`=3, `WORD_GAP_UNITS`=7.

1. Key high 4 cycles, then idle 40 cycles -> `dot` once, `send` 13 cycles after `key_db` fall, second `send` 29 cycles after the fall, then IDLE; `sym_count` 1→0.
2. Key high 7 cycles -> `dot`; key high 8 cycles -> `dash`; boundary at 8 confirmed.
3. Dot, 4-cycle gap, dash, 4-cycle gap, dot, then 12+ idle cycles -> dot, dash, dot, then `send` ("R"); no space `send` if the key is pressed again within 28 cycles of release.
4. Seven 4-cycle presses with 4-cycle gaps -> six strobes, seventh suppressed; `overflow` = 1 and `sym_count` = 6 until the letter `send`, then both 0.
5. `clear` asserted during PRESS -> single `dec_reset`, LOCKOUT; no `dot`/`dash` on release; next press decodes normally.
6. Raw key toggling every cycle for 10 cycles -> `key_active` stays 0; `reset` = 0 mid-GAP -> all outputs 0, no `send`.
